memory_stage: RTL

// - Memory (M) stage of the 5-stage RV32 pipeline, directly downstream of the Execute stage.
// - Consumes the EX/MEM register outputs and performs word/byte data-memory access over a
//   req/ack handshake with variable latency.
// - Stalls the pipeline while an access is outstanding, then latches the MEM/WB register

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_align.sv | 31 +++
 rtl/memory_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage of the RV32 pipeline.
package mem_pkg;

  // Access FSM: IDLE issues requests, WAIT holds one until ack or timeout.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Access size selector carried on MemTypeM.
  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;

endpackage

// File: rtl/mem_align.sv
// Lane steering for word/byte accesses: byte enables, replicated store data,
// and right-aligned, zero-extended load data.
module mem_align
  import mem_pkg::*;
(
  input  logic        mem_type,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  // Word accesses pass straight through; byte accesses pick one lane.
  always_comb begin
    wstrb = 4'hF;
    wdata = store_data;
    rdata = load_data;
    if (mem_type == MEM_BYTE) begin
      wdata = {4{store_data[7:0]}};
      case (byte_sel)
        2'd0: begin wstrb = 4'b0001; rdata = {24'b0, load_data[7:0]};   end
        2'd1: begin wstrb = 4'b0010; rdata = {24'b0, load_data[15:8]};  end
        2'd2: begin wstrb = 4'b0100; rdata = {24'b0, load_data[23:16]}; end
        default: begin wstrb = 4'b1000; rdata = {24'b0, load_data[31:24]}; end
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: issues data-memory accesses, stalls while one is outstanding,
// abandons it after a bounded wait, and latches the MEM/WB register.
//
// Handshake: mem_req is raised while an access is pending and held, with
// mem_we/mem_addr/mem_wdata/mem_wstrb stable, until the cycle in which
// mem_ack is high; that cycle completes the access and mem_rdata is valid
// only then. mem_ack may coincide with the first cycle of mem_req (zero wait).
// mem_ack while no access is pending is ignored.
module memory_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic        MemTypeM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic        MemErr,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output mem_state_t  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  mem_state_t    state;
  mem_state_t    state_next;
  logic [CW-1:0] count;
  logic          access;
  logic          timeout_hit;
  logic [31:0]   aligned_rdata;

  assign access    = ResultSrcM | MemWriteM;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUResultM[31:2], 2'b00};
  assign dbg_state = state;

  mem_align u_align (
    .mem_type   (MemTypeM),
    .byte_sel   (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .load_data  (mem_rdata),
    .wstrb      (mem_wstrb),
    .wdata      (mem_wdata),
    .rdata      (aligned_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, request, timeout detection and stall.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (access && !mem_ack) state_next = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          state_next = IDLE;
        end else if (count == LAST_WAIT) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    mem_req = access && (state == IDLE || state == WAIT) && !rst;
    StallM  = access && !mem_ack && !timeout_hit;
  end

  // Wait-cycle counter: zero in IDLE, counts WAIT cycles, saturates.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) count <= '0;
    else if (count != COUNT_MAX) count <= count + 1'b1;
  end

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst)              MemErr <= 1'b0;
    else if (timeout_hit) MemErr <= 1'b1;
  end

  // MEM/WB register: capture when the stage advances, bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
    end else if (StallM || timeout_hit) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      RdW        <= '0;
    end else begin
      // Stores never write rd; a load to x0 completes but writes nothing.
      RegWriteW  <= RegWriteM && !MemWriteM && !(ResultSrcM && RdM == 5'd0);
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      RdW        <= RdM;
      if (ResultSrcM && mem_ack) ReadDataW <= aligned_rdata;
    end
  end

endmodule
